// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through and a DEPTH=0 pass-through mode.
// Pointers wrap explicitly at FIFO_DEPTH-1, so non-power-of-two depths work.
module fifo_v3 #(
    parameter bit           FALL_THROUGH = 1'b0,
    parameter int unsigned  DATA_WIDTH   = 32,
    parameter int unsigned  DEPTH        = 8,
    parameter type          dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned FIFO_DEPTH = (DEPTH > 0) ? DEPTH : 1;
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(FIFO_DEPTH);

    logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
    logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  mem_we;
    dtype                  mem_q [FIFO_DEPTH];

    // No clock gating on the storage, so test mode has nothing to bypass.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    always_comb begin
        full_o  = 1'b0;
        empty_o = 1'b1;
        usage_o = '0;
        if (DEPTH == 0) begin
            empty_o = ~push_i;
            full_o  = ~pop_i;
        end else begin
            full_o  = (cnt_q == FULL_CNT);
            empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);
            usage_o = cnt_q[ADDR_DEPTH-1:0];
        end
    end

    always_comb begin
        read_ptr_d  = read_ptr_q;
        write_ptr_d = write_ptr_q;
        cnt_d       = cnt_q;
        mem_we      = 1'b0;
        data_o      = (DEPTH == 0) ? data_i : mem_q[read_ptr_q];

        if (push_i && !full_o) begin
            mem_we      = 1'b1;
            write_ptr_d = (write_ptr_q == LAST_PTR) ? '0 : write_ptr_q + 1'b1;
            cnt_d       = cnt_q + 1'b1;
        end

        if (pop_i && !empty_o) begin
            read_ptr_d = (read_ptr_q == LAST_PTR) ? '0 : read_ptr_q + 1'b1;
            cnt_d      = (push_i && !full_o) ? cnt_q : cnt_q - 1'b1;
        end

        // Push and pop on an empty fall-through FIFO bypass the storage entirely.
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                read_ptr_d  = read_ptr_q;
                write_ptr_d = write_ptr_q;
                cnt_d       = cnt_q;
                mem_we      = 1'b0;
            end
        end

        if (DEPTH == 0) begin
            read_ptr_d  = read_ptr_q;
            write_ptr_d = write_ptr_q;
            cnt_d       = cnt_q;
            mem_we      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            cnt_q       <= '0;
        end else if (flush_i) begin
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            cnt_q       <= '0;
        end else begin
            read_ptr_q  <= read_ptr_d;
            write_ptr_q <= write_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (mem_we && !flush_i) begin
            mem_q[write_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_fifo_v3.sv
// Directed bench for fifo_v3: normal, fall-through, depth-3 and pass-through
// instances share inputs and are reset between scenarios.
module tb_fifo_v3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       testmode = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data = 8'h00;

    logic       full_n, empty_n, full_f, empty_f, full_3, empty_3, full_p, empty_p;
    logic [1:0] usage_n, usage_f, usage_3;
    logic [0:0] usage_p;
    logic [7:0] dout_n, dout_f, dout_3, dout_p;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_n (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .full_o(full_n), .empty_o(empty_n), .usage_o(usage_n),
        .data_i(data), .push_i(push), .data_o(dout_n), .pop_i(pop));

    fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_f (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .full_o(full_f), .empty_o(empty_f), .usage_o(usage_f),
        .data_i(data), .push_i(push), .data_o(dout_f), .pop_i(pop));

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .full_o(full_3), .empty_o(empty_3), .usage_o(usage_3),
        .data_i(data), .push_i(push), .data_o(dout_3), .pop_i(pop));

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_p (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .full_o(full_p), .empty_o(empty_p), .usage_o(usage_p),
        .data_i(data), .push_i(push), .data_o(dout_p), .pop_i(pop));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [7:0] mq[$];
    logic [7:0] nxt;
    bit   [1:0] ops [18] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b10,
                             2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [7:0] seq [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        // Reset state
        #1;
        chk("rst_empty", 32'(empty_n), 32'd1);
        chk("rst_full",  32'(full_n),  32'd0);
        chk("rst_usage", 32'(usage_n), 32'd0);
        chk("rst_data",  32'(dout_n),  32'd0);
        #1;
        rst_n = 1'b1;
        cyc();

        // Normal-mode ordering, full, dropped push
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            data = seq[i];
            cyc();
        end
        chk("n_full",   32'(full_n),  32'd1);
        chk("n_usage0", 32'(usage_n), 32'd0);
        data = 8'hEE;
        cyc();
        push = 1'b0;
        chk("n_full_e", 32'(full_n),  32'd1);
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("n_order", 32'(dout_n), 32'(seq[i]));
            cyc();
        end
        pop = 1'b0;
        #1;
        chk("n_empty",  32'(empty_n), 32'd1);
        chk("n_usage",  32'(usage_n), 32'd0);
        chk("n_stale",  32'(dout_n),  32'(seq[0]));
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        #1;
        chk("n_underflow_use",  32'(usage_n), 32'd0);
        chk("n_underflow_full", 32'(full_n),  32'd0);
        chk("n_underflow_emp",  32'(empty_n), 32'd1);

        // Fall-through
        do_reset();
        cyc();
        data = 8'h05;
        push = 1'b1;
        pop  = 1'b1;
        #1;
        chk("ft_data",  32'(dout_f),  32'h05);
        chk("ft_empty", 32'(empty_f), 32'd0);
        chk("nft_empty", 32'(empty_n), 32'd1);
        cyc();
        push = 1'b0;
        pop  = 1'b0;
        #1;
        chk("ft_usage", 32'(usage_f), 32'd0);
        chk("ft_empty2", 32'(empty_f), 32'd1);
        data = 8'h09;
        push = 1'b1;
        #1;
        chk("ft_data2", 32'(dout_f), 32'h09);
        cyc();
        push = 1'b0;
        #1;
        chk("ft_usage1", 32'(usage_f), 32'd1);
        chk("ft_hold",   32'(dout_f),  32'h09);
        chk("ft_nempty", 32'(empty_f), 32'd0);

        // Depth 3 with pointer wrap
        do_reset();
        cyc();
        mq.delete();
        nxt = 8'h31;
        for (int i = 0; i < 18; i++) begin
            bit pv, ppv;
            push = ops[i][1];
            pop  = ops[i][0];
            data = nxt;
            #1;
            chk("d3_full",  32'(full_3),  32'(mq.size() == 3));
            chk("d3_usage", 32'(usage_3), 32'(mq.size()));
            chk("d3_empty", 32'(empty_3), 32'(mq.size() == 0));
            if (pop && mq.size() > 0) chk("d3_data", 32'(dout_3), 32'(mq[0]));
            pv  = push && (mq.size() < 3);
            ppv = pop && (mq.size() > 0);
            if (ppv) void'(mq.pop_front());
            if (pv) begin
                mq.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            cyc();
        end
        push = 1'b0;
        pop  = 1'b0;

        // Flush beats a simultaneous push
        do_reset();
        cyc();
        push = 1'b1;
        data = 8'h11;
        cyc();
        data = 8'h22;
        cyc();
        chk("fl_usage2", 32'(usage_n), 32'd2);
        data  = 8'h33;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        push  = 1'b0;
        #1;
        chk("fl_empty", 32'(empty_n), 32'd1);
        chk("fl_usage", 32'(usage_n), 32'd0);
        push = 1'b1;
        data = 8'h44;
        cyc();
        data = 8'h55;
        cyc();
        push = 1'b0;
        pop  = 1'b1;
        #1;
        chk("fl_head", 32'(dout_n), 32'h44);
        cyc();
        cyc();
        pop = 1'b0;
        #1;
        chk("fl_slot2", 32'(dout_n), 32'h00);
        chk("fl_empty2", 32'(empty_n), 32'd1);

        // Pass-through
        do_reset();
        data = 8'h07;
        push = 1'b1;
        pop  = 1'b0;
        #1;
        chk("pt_empty", 32'(empty_p), 32'd0);
        chk("pt_full",  32'(full_p),  32'd1);
        chk("pt_data",  32'(dout_p),  32'h07);
        chk("pt_usage", 32'(usage_p), 32'd0);
        push = 1'b0;
        pop  = 1'b1;
        #1;
        chk("pt_empty2", 32'(empty_p), 32'd1);
        chk("pt_full2",  32'(full_p),  32'd0);
        pop = 1'b0;

        // Asynchronous reset mid-operation
        do_reset();
        cyc();
        push = 1'b1;
        data = 8'h61;
        cyc();
        data = 8'h62;
        cyc();
        push = 1'b0;
        chk("ar_usage2", 32'(usage_n), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("ar_empty", 32'(empty_n), 32'd1);
        chk("ar_usage", 32'(usage_n), 32'd0);
        chk("ar_data",  32'(dout_n),  32'd0);
        #1;
        rst_n = 1'b1;
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        #1;
        chk("ar_pop_empty", 32'(empty_n), 32'd1);
        chk("ar_pop_usage", 32'(usage_n), 32'd0);
        chk("ar_pop_full",  32'(full_n),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
